// File: rtl/pc_stack_if.sv
// Control/status bundle between the decoder/control unit and the program counter.
interface pc_stack_if #(
  parameter int ADDR_W = 12,
  parameter int OFF_W  = 8,
  parameter int CNT_W  = 3
);
  logic              no_inc;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_addr;
  logic              call;
  logic              ret;
  logic              br;
  logic [OFF_W-1:0]  br_off;
  logic              clr_err;
  logic [ADDR_W-1:0] addr_out;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_empty;
  logic              stack_full;
  logic              err_ovf;
  logic              err_unf;

  // control unit side
  modport master (
    output no_inc, jmp, jmp_addr, call, ret, br, br_off, clr_err,
    input  addr_out, stack_cnt, stack_empty, stack_full, err_ovf, err_unf
  );

  // program counter side
  modport slave (
    input  no_inc, jmp, jmp_addr, call, ret, br, br_off, clr_err,
    output addr_out, stack_cnt, stack_empty, stack_full, err_ovf, err_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, call/return through a hardware
// return-address stack, configurable reset vector/step and sticky stack errors.
module pc_stack_unit #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int STEP        = 1,
  parameter int OFF_W       = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_stack_if.slave bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RST_V    = ADDR_W'(RESET_ADDR);

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stk;
  logic [ADDR_W-1:0] addr_q, addr_nxt, br_ext, ret_addr;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              empty_q, full_q, ovf_q, unf_q;
  logic              push, pop, ovf_set, unf_set;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign br_ext   = ADDR_W'(signed'(bus.br_off));
  assign ret_addr = addr_q + ADDR_W'(1);
  assign wr_idx   = IDX_W'(cnt_q);
  assign rd_idx   = IDX_W'(cnt_q - CNT_W'(1));

  // Priority-resolved next address and stack/flag actions; one action per cycle.
  always_comb begin
    addr_nxt = addr_q + STEP_V;
    push     = 1'b0;
    pop      = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (bus.jmp) begin
      addr_nxt = bus.jmp_addr;
    end else if (bus.call) begin
      addr_nxt = bus.jmp_addr;        // jump is taken even when the push is dropped
      if (full_q) ovf_set = 1'b1;
      else        push    = 1'b1;
    end else if (bus.ret) begin
      if (empty_q) begin
        addr_nxt = addr_q;            // underflow holds rather than advancing
        unf_set  = 1'b1;
      end else begin
        addr_nxt = stk[rd_idx];
        pop      = 1'b1;
      end
    end else if (bus.br) begin
      addr_nxt = addr_q + br_ext;
    end else if (bus.no_inc) begin
      addr_nxt = addr_q;
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (push)     cnt_nxt = cnt_q + CNT_W'(1);
    else if (pop) cnt_nxt = cnt_q - CNT_W'(1);
  end

  // Architectural state: address, occupancy and sticky errors (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= RST_V;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_nxt;
      cnt_q   <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == FULL_CNT);
      ovf_q   <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q   <= unf_set | (unf_q & ~bus.clr_err);
    end
  end

  // Stack storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (push && rst_n) stk[wr_idx] <= ret_addr;
  end

  assign bus.addr_out    = addr_q;
  assign bus.stack_cnt   = cnt_q;
  assign bus.stack_empty = empty_q;
  assign bus.stack_full  = full_q;
  assign bus.err_ovf     = ovf_q;
  assign bus.err_unf     = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed plus random bench for pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;
  localparam int ADDR_W = 12, DEPTH = 4, RST = 'h010, STEP = 1, OFF_W = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_stack_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();
  pc_stack_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(RST),
                  .STEP(STEP), .OFF_W(OFF_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0, fails = 0;
  int m_addr;
  int m_stk[$];
  bit m_ovf, m_unf;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check_val({tag, ".addr"},  32'(bus.addr_out),    32'(m_addr));
    check_val({tag, ".cnt"},   32'(bus.stack_cnt),   32'(m_stk.size()));
    check_val({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
    check_val({tag, ".full"},  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
    check_val({tag, ".ovf"},   32'(bus.err_ovf),     32'(m_ovf));
    check_val({tag, ".unf"},   32'(bus.err_unf),     32'(m_unf));
  endtask

  task automatic model_reset();
    m_addr = RST;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One clock of architectural behaviour from the rule list.
  task automatic model_step();
    bit so = 0, su = 0;
    int off;
    if (bus.jmp) m_addr = int'(bus.jmp_addr);
    else if (bus.call) begin
      if (m_stk.size() == DEPTH) so = 1;
      else m_stk.push_back((m_addr + 1) & MASK);
      m_addr = int'(bus.jmp_addr);
    end else if (bus.ret) begin
      if (m_stk.size() == 0) su = 1;
      else m_addr = m_stk.pop_back();
    end else if (bus.br) begin
      off = int'(bus.br_off);
      if (off >= (1 << (OFF_W - 1))) off -= (1 << OFF_W);
      m_addr = (m_addr + off) & MASK;
    end else if (!bus.no_inc) m_addr = (m_addr + STEP) & MASK;
    m_ovf = so | (m_ovf & ~bus.clr_err);
    m_unf = su | (m_unf & ~bus.clr_err);
  endtask

  task automatic drive(bit j, bit c, bit r, bit b, bit ni, bit ce, int ja, int bo);
    bus.jmp = j; bus.call = c; bus.ret = r; bus.br = b;
    bus.no_inc = ni; bus.clr_err = ce;
    bus.jmp_addr = ADDR_W'(ja); bus.br_off = OFF_W'(bo);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all("reset");
    check_val("reset_addr", 32'(bus.addr_out), 32'h010);
    rst_n = 1'b1;

    // free run and stall
    tick("run1"); check_val("run1_v", 32'(bus.addr_out), 32'h011);
    tick("run2"); check_val("run2_v", 32'(bus.addr_out), 32'h012);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick("stall1"); check_val("stall1_v", 32'(bus.addr_out), 32'h012);
    tick("stall2"); check_val("stall2_v", 32'(bus.addr_out), 32'h012);
    idle();
    tick("resume"); check_val("resume_v", 32'(bus.addr_out), 32'h013);

    // wrap and negative branch
    drive(1, 0, 0, 0, 0, 0, 'hFFF, 0); tick("jmp_fff");
    idle(); tick("wrap"); check_val("wrap_v", 32'(bus.addr_out), 32'h000);
    drive(1, 0, 0, 0, 0, 0, 'h005, 0); tick("jmp_005");
    drive(0, 0, 0, 1, 0, 0, 0, 'h80); tick("br_neg");
    check_val("br_neg_v", 32'(bus.addr_out), 32'hF85);

    // nested calls
    drive(1, 0, 0, 0, 0, 0, 'h020, 0); tick("jmp_020");
    drive(0, 1, 0, 0, 0, 0, 'h100, 0); tick("call1");
    idle(); tick("inc_101");
    drive(0, 1, 0, 0, 0, 0, 'h200, 0); tick("call2");
    check_val("nest_cnt", 32'(bus.stack_cnt), 32'd2);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick("ret1");
    check_val("ret1_v", 32'(bus.addr_out), 32'h102);
    tick("ret2"); check_val("ret2_v", 32'(bus.addr_out), 32'h021);
    check_val("nest_empty", 32'(bus.stack_empty), 32'd1);

    // overflow / underflow
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 0, 'h400 + i * 'h10, 0); tick("ovf_call");
    end
    check_val("ovf_addr", 32'(bus.addr_out), 32'h440);
    check_val("ovf_cnt", 32'(bus.stack_cnt), 32'd4);
    check_val("ovf_flag", 32'(bus.err_ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0); tick("unf_ret");
    end
    check_val("unf_hold", 32'(bus.addr_out), 32'h022);
    check_val("unf_flag", 32'(bus.err_unf), 32'd1);
    drive(0, 0, 0, 0, 1, 1, 0, 0); tick("clr_err");
    check_val("clr_ovf", 32'(bus.err_ovf), 32'd0);
    check_val("clr_unf", 32'(bus.err_unf), 32'd0);

    // priority
    drive(0, 1, 0, 0, 0, 0, 'h050, 0); tick("pre_call");
    drive(1, 1, 1, 1, 1, 0, 'h300, 'h10); tick("prio_all");
    check_val("prio_all_v", 32'(bus.addr_out), 32'h300);
    check_val("prio_all_cnt", 32'(bus.stack_cnt), 32'd1);
    drive(0, 1, 1, 0, 0, 0, 'h360, 0); tick("prio_cr");
    check_val("prio_cr_cnt", 32'(bus.stack_cnt), 32'd2);

    // async reset mid-cycle with a call pending
    drive(0, 1, 0, 0, 0, 0, 'h500, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    check_val("areset_addr", 32'(bus.addr_out), 32'h010);
    idle();
    #3 rst_n = 1'b1;
    tick("post_rst"); check_val("post_rst_v", 32'(bus.addr_out), 32'h011);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
            int'($urandom_range(0, MASK)), int'($urandom_range(0, 255)));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
